ddr_axi_burst_tester: RTL
=========================

# ddr_axi_burst_tester

Parametrised AXI4 DDR self-test master that replaces the single-word write/read smoke test. It sits on the DDR controller's AXI slave port after calibration (`ddr_ready`). On request it writes a configurable number of multi-beat bursts with a selectable data pattern, reads them back, and compares every beat. It reports pass/fail, an error count and the first failing address to the status LED and debug logic.

## Interface
- `ADDR_W`, 32, AXI address width
- `DATA_W`, 32, AXI data width; must be a power of two, 32..128
- `BASE_ADDR`, 32'h8100_0000, first tested byte address; must be aligned to `DATA_W/8`
- `BURST_LEN`, 4, beats per burst, 1..256
- `NUM_BURSTS`, 16, bursts per run, 1..65535

Ports, clock and reset first:
- `clk` in 1: clock
- `rstn` in 1: reset, synchronous, active-low
- `ddr_ready` in 1: controller calibrated
- `start` in 1: single-cycle run request
- `mode` in 2: data pattern select, sampled at start. 0 = address; 1 = ~address; 2 = fixed 32'h1212_1212 replicated across `DATA_W`; 3 = walking one
- AW channel: `awaddr` out `ADDR_W`, `awlen` out 8, `awsize` out 3, `awburst` out 2, `awvalid` out 1, `awready` in 1
- W channel: `wdata` out `DATA_W`, `wstrb` out `DATA_W/8`, `wlast` out 1, `wvalid` out 1, `wready` in 1
- B channel: `bresp` in 2, `bvalid` in 1, `bready` out 1
- AR channel: `araddr` out `ADDR_W`, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arvalid` out 1, `arready` in 1
- R channel: `rdata` in `DATA_W`, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1
- Status outputs:
  - `busy` out 1
  - `done` out 1
  - `pass` out 1
  - `err_count` out 16
  - `first_err_addr` out `ADDR_W`

## Operation
- Constant AXI fields:
  - `awlen` = `arlen` = `BURST_LEN-1`
  - `awsize` = `arsize` = log2(`DATA_W/8`)
  - `awburst` = `arburst` = 2'b01 (INCR)
  - `wstrb` = all ones
  - `bready` = `rready` = 1
- Burst b (0-based) address: `BASE_ADDR + b*BURST_LEN*(DATA_W/8)`.
- Beat address: the burst address plus beat index × `DATA_W/8`.
- Pattern per beat, computed from the beat address A:
  - mode 0: A zero-extended or truncated to `DATA_W`
  - mode 1: the bitwise inverse of mode 0
  - mode 2: constant
  - mode 3: `1 << (global beat index mod DATA_W)`
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, FINISH.
  - IDLE → WR_ADDR: `start & ddr_ready`. Clears `err_count`, `first_err_addr`, `done`, `pass`; latches `mode`; burst counter = 0.
  - WR_ADDR: `awvalid` = 1 until `awready`. Then → WR_DATA.
  - WR_DATA: `wvalid` = 1; beat counter advances on `wvalid & wready`; `wlast` = 1 on beat `BURST_LEN-1`. The last handshake → WR_RESP.
  - WR_RESP: on `bvalid`:
    - `bresp` ≠ 2'b00 → error count +1; if first error, capture the burst address.
    - Then → WR_ADDR for the next burst, or → RD_ADDR with burst counter = 0 after burst `NUM_BURSTS-1`.
  - RD_ADDR: `arvalid` = 1 until `arready`. Then → RD_DATA.
  - RD_DATA: each `rvalid` beat is compared with the expected pattern.
    - An error is `rdata` mismatch, `rresp` ≠ 0, or `rlast` ≠ (beat == `BURST_LEN-1`).
    - A beat with any error counts once; the first error captures the beat address.
    - After the final beat → next RD_ADDR, or → FINISH after the last burst.
  - FINISH: `done` = 1, `pass` = (`err_count` == 0), `busy` = 0 → IDLE. `done` and `pass` hold until the next accepted `start`.
- `err_count` saturates at 16'hFFFF.
- `start` is ignored while `busy`.
- Reset values: all valids 0, `wlast` 0, `busy` 0, `done` 0, `pass` 0, `err_count` 0, `first_err_addr` 0, FSM IDLE.
- `ddr_ready` low in any non-IDLE state:
  - Next cycle: all valids 0, `busy` 0, `done` 0, `pass` 0, FSM IDLE. `err_count` is retained.
  - No further handshakes complete.

## Timing
- `awvalid` rises the cycle after `start` is accepted.
- Only one outstanding transaction at a time; AW precedes W; no W beat is issued before the AW handshake.
- While `valid & !ready`, the payload (`*addr`, `wdata`, `wlast`) is held stable.
- The next `wdata` is presented in the cycle after a handshake. Back-to-back beats at 1/cycle are required when `wready` is held high.
- The comparison is registered: `err_count` updates 1 cycle after the failing `rvalid` beat.
- `done` rises 1 cycle after the last read beat, or 2 cycles if that beat failed so the final count is included.
- Minimum run length with an ideal slave (1-cycle ready, no wait): about `NUM_BURSTS*(2*BURST_LEN+5)` cycles.

## Test plan
- Mode 0, ideal memory slave, `BURST_LEN`=4, `NUM_BURSTS`=2:
  - awaddr sequence 0x8100_0000 then 0x8100_0010.
  - wdata 0x8100_0000, 0x8100_0004, …; `wlast` on beats 3 and 7.
  - Result: `done`=1, `pass`=1, `err_count`=0.
- Same run, slave corrupts the read beat at 0x8100_0008 → `err_count`=1, `first_err_addr`=0x8100_0008, `pass`=0.
- `bresp`=2'b10 on burst 1 and all data correct → `err_count`=1, `first_err_addr`=0x8100_0010.
- Random `awready`/`wready`/`arready`/`rvalid` stalls, mode 1 → `wdata` stable while stalled, no dropped or duplicated beats, `pass`=1.
- `ddr_ready` dropped during WR_DATA → valids 0 next cycle, `busy`=0. A later `start` reruns from 0x8100_0000 with `err_count` cleared.
- `start` asserted while `busy` → ignored; a second `start` after `done` → `done` falls, the run repeats, `pass`=1.

Source files
------------

// File: rtl/ddr_axi_burst_tester.sv
// AXI4 DDR self-test master: writes NUM_BURSTS bursts of a selectable pattern,
// reads them back, compares every beat and reports pass/fail with the first failing address.
module ddr_axi_burst_tester #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8100_0000,
  parameter int                BURST_LEN  = 4,
  parameter int                NUM_BURSTS = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ddr_ready,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_W-1:0]     araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_W-1:0]     first_err_addr
);

  localparam int                BYTES       = DATA_W / 8;
  localparam int                SIZE        = $clog2(BYTES);
  localparam int                IDX_W       = $clog2(DATA_W);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * BYTES);
  localparam logic [7:0]        LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [15:0]       LAST_BURST  = 16'(NUM_BURSTS - 1);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q;
  logic [15:0]        burst_cnt_q;
  logic [7:0]         beat_cnt_q;
  logic [ADDR_W-1:0]  burst_addr_q;
  logic [ADDR_W-1:0]  beat_addr;
  logic [DATA_W-1:0]  expected;
  logic               cmp_err_q;
  logic [ADDR_W-1:0]  cmp_addr_q;
  logic [15:0]        err_count_q;
  logic [ADDR_W-1:0]  first_err_addr_q;
  logic               done_q, pass_q;
  logic               start_acc, abort;
  logic               aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic               last_beat, last_burst;
  logic               err_hit;
  logic [ADDR_W-1:0]  err_addr;

  // Walking-one position is the global beat index, recovered from the beat's offset from BASE_ADDR.
  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a);
    logic [IDX_W-1:0] idx;
    idx = IDX_W'((a - BASE_ADDR) >> SIZE);
    pattern = '0;
    case (m)
      2'd0:    pattern = DATA_W'(a);
      2'd1:    pattern = ~DATA_W'(a);
      2'd2:    pattern = {(DATA_W/32){32'h1212_1212}};
      default: pattern[idx] = 1'b1;
    endcase
  endfunction

  assign beat_addr  = burst_addr_q + (ADDR_W'(beat_cnt_q) << SIZE);
  assign expected   = pattern(mode_q, beat_addr);
  assign last_beat  = (beat_cnt_q == LAST_BEAT);
  assign last_burst = (burst_cnt_q == LAST_BURST);

  assign start_acc = (state_q == IDLE) && start && ddr_ready;
  assign abort     = (state_q != IDLE) && !ddr_ready;
  assign aw_hs     = ddr_ready && (state_q == WR_ADDR) && awready;
  assign w_hs      = ddr_ready && (state_q == WR_DATA) && wready;
  assign b_hs      = ddr_ready && (state_q == WR_RESP) && bvalid;
  assign ar_hs     = ddr_ready && (state_q == RD_ADDR) && arready;
  assign r_hs      = ddr_ready && (state_q == RD_DATA) && rvalid;

  assign awaddr  = burst_addr_q;
  assign araddr  = burst_addr_q;
  assign wdata   = expected;
  assign awlen   = LAST_BEAT;
  assign arlen   = LAST_BEAT;
  assign awsize  = 3'(SIZE);
  assign arsize  = 3'(SIZE);
  assign awburst = 2'b01;
  assign arburst = 2'b01;
  assign wstrb   = '1;
  assign bready  = 1'b1;
  assign rready  = 1'b1;

  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;
  assign done           = done_q;
  assign pass           = pass_q;

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Valids are gated by ddr_ready so nothing can complete once calibration is lost.
  always_comb begin
    state_d = state_q;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    wlast   = 1'b0;
    arvalid = 1'b0;
    busy    = (state_q != IDLE) && (state_q != FINISH);
    case (state_q)
      IDLE:    if (start_acc) state_d = WR_ADDR;
      WR_ADDR: begin
        awvalid = ddr_ready;
        if (aw_hs) state_d = WR_DATA;
      end
      WR_DATA: begin
        wvalid = ddr_ready;
        wlast  = last_beat;
        if (w_hs && last_beat) state_d = WR_RESP;
      end
      WR_RESP: if (b_hs) state_d = last_burst ? RD_ADDR : WR_ADDR;
      RD_ADDR: begin
        arvalid = ddr_ready;
        if (ar_hs) state_d = RD_DATA;
      end
      RD_DATA: if (r_hs && last_beat) state_d = last_burst ? FINISH : RD_ADDR;
      FINISH:  if (!cmp_err_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mode_q       <= 2'd0;
      burst_cnt_q  <= '0;
      beat_cnt_q   <= '0;
      burst_addr_q <= BASE_ADDR;
      cmp_err_q    <= 1'b0;
      cmp_addr_q   <= '0;
    end else begin
      cmp_err_q <= 1'b0;
      if (start_acc) begin
        mode_q       <= mode;
        burst_cnt_q  <= '0;
        beat_cnt_q   <= '0;
        burst_addr_q <= BASE_ADDR;
      end
      if (w_hs || r_hs) beat_cnt_q <= last_beat ? '0 : beat_cnt_q + 8'd1;
      if (b_hs || (r_hs && last_beat)) begin
        if (last_burst) begin
          burst_cnt_q  <= '0;
          burst_addr_q <= BASE_ADDR;
        end else begin
          burst_cnt_q  <= burst_cnt_q + 16'd1;
          burst_addr_q <= burst_addr_q + BURST_BYTES;
        end
      end
      if (r_hs) begin
        cmp_err_q  <= (rdata != expected) || (rresp != 2'b00) || (rlast != last_beat);
        cmp_addr_q <= beat_addr;
      end
    end
  end

  // Write-response errors and registered read-compare errors never coincide.
  assign err_hit  = (b_hs && (bresp != 2'b00)) || cmp_err_q;
  assign err_addr = (b_hs && (bresp != 2'b00)) ? burst_addr_q : cmp_addr_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
    end else if (start_acc) begin
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
    end else begin
      if (err_hit) begin
        if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
        if (err_count_q == 16'd0)    first_err_addr_q <= err_addr;
      end
      if (abort) begin
        done_q <= 1'b0;
        pass_q <= 1'b0;
      end else if ((state_q == FINISH) && !cmp_err_q) begin
        done_q <= 1'b1;
        pass_q <= (err_count_q == 16'd0);
      end
    end
  end

endmodule
